// File: rtl/modulator16bit_if.sv
// modulator16bit_if: sample handshake and modulated-output bundle for modulator16bit.
// UNDERRUN exists only when SDM_UNDERRUN_EN is defined.
interface modulator16bit_if #(parameter int FRAME_BITS = 8);
  logic [15:0] D;
  logic VALID;
  logic READY;
  logic MODE;
  logic VMOD;
  logic [FRAME_BITS-1:0] timer;
  logic [FRAME_BITS-1:0] count;
  logic FRAME_DONE;
`ifdef SDM_UNDERRUN_EN
  logic UNDERRUN;
`endif
  modport master (
`ifdef SDM_UNDERRUN_EN
    input UNDERRUN,
`endif
    output D, VALID, MODE,
    input READY, VMOD, timer, count, FRAME_DONE
  );
  modport slave (
`ifdef SDM_UNDERRUN_EN
    output UNDERRUN,
`endif
    input D, VALID, MODE,
    output READY, VMOD, timer, count, FRAME_DONE
  );
endinterface

// File: rtl/modulator16bit.sv
// modulator16bit: frame-based sigma-delta/PWM 1-bit modulator of 16-bit samples.
// Define SDM_UNDERRUN_EN to add the UNDERRUN port.
module modulator16bit #(
  parameter int FRAME_BITS = 8
) (
  input logic CLK,
  input logic RST,
  modulator16bit_if.slave bus
);
  localparam int F = FRAME_BITS;
  logic [15:0] r_shadow;
  logic r_full;
  logic [F-1:0] r_k;
  logic [F-1:0] r_timer;
  logic [F-1:0] r_acc;
  logic [F-1:0] r_count;
  logic r_mode;
  logic r_vmod;
  logic r_done;
  logic w_bnd;
  logic w_mode;
  logic w_vmod;
  logic [F-1:0] w_k;
  logic [F-1:0] w_t_next;
  logic [F-1:0] w_acc;
  logic [F:0] w_sum;
  logic w_unused_shadow;
  // Outputs are computed one edge ahead so VMOD/timer/count/FRAME_DONE share a phase.
  always_comb begin
    w_bnd = &r_timer;
    w_k = (w_bnd && r_full) ? r_shadow[15 -: F] : r_k;
    w_mode = w_bnd ? bus.MODE : r_mode;
    w_t_next = r_timer + F'(1);
    w_acc = w_bnd ? '0 : r_acc;
    w_sum = {1'b0, w_acc} + {1'b0, w_k};
    w_vmod = w_mode ? (w_t_next < w_k) : w_sum[F];
  end
  assign w_unused_shadow = ^r_shadow;
`ifdef SDM_UNDERRUN_EN
  logic r_underrun;
  always_ff @(posedge CLK)
    r_underrun <= RST ? 1'b0 : (w_bnd && !r_full);
  assign bus.UNDERRUN = r_underrun;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shadow <= '0;
      r_full <= 1'b0;
      r_k <= '0;
      r_timer <= '0;
      r_acc <= '0;
      r_count <= '0;
      r_mode <= 1'b0;
      r_vmod <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_timer <= w_t_next;
      r_acc <= w_sum[F-1:0];
      r_k <= w_k;
      r_mode <= w_mode;
      r_vmod <= w_vmod;
      r_count <= (w_bnd ? '0 : r_count) + F'(w_vmod);
      r_done <= &w_t_next;
      if (bus.VALID && !r_full) begin
        r_shadow <= bus.D;
        r_full <= 1'b1;
      end else if (w_bnd) begin
        r_full <= 1'b0;
      end
    end
  end
  assign bus.READY = ~r_full;
  assign bus.VMOD = r_vmod;
  assign bus.timer = r_timer;
  assign bus.count = r_count;
  assign bus.FRAME_DONE = r_done;
endmodule
